// File: rtl/mix_col_serial_if.sv
// Bundles both valid/ready handshakes of the column-serial MixColumns engine
// plus its debug observation signals.
interface mix_col_serial_if;
  // A transfer happens on a rising edge where valid and ready are both high;
  // the sender holds valid and its data stable until that edge.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [1:0]   col_idx;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, busy, col_idx
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, busy, col_idx
  );
endinterface

// File: rtl/mix_col_serial.sv
// AES MixColumns engine pushing one 32-bit column per cycle through a single
// shared mixCol32; the final round bypasses the mix at identical latency.
module mix_col_serial #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  mix_col_serial_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_src;
  logic [127:0] r_out;
  logic         r_byp;
  logic [1:0]   r_col;
  logic [31:0]  w_src_col;
  logic [31:0]  w_mix_col;
  logic [31:0]  w_res_col;
  logic         w_in_ready;
  logic         w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte a0 is the top byte of the column (row 0).
  function automatic logic [31:0] mix_col32(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    w_src_col = r_src[127:96];
    case (r_col)
      2'd0:    w_src_col = r_src[127:96];
      2'd1:    w_src_col = r_src[95:64];
      2'd2:    w_src_col = r_src[63:32];
      default: w_src_col = r_src[31:0];
    endcase
  end

  assign w_mix_col = mix_col32(w_src_col);
  assign w_res_col = r_byp ? w_src_col : w_mix_col;

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = RUN;
      end
      RUN: begin
        if (r_col == 2'd3) w_next = DONE;
      end
      DONE: begin
        // Output drain and next accept can share one edge.
        w_in_ready = bus.out_ready;
        if (bus.out_ready) w_next = bus.in_valid ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept      = bus.in_valid & w_in_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == RUN);
  assign bus.out_data  = r_out;
  assign bus.col_idx   = r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_out   <= '0;
      r_byp   <= 1'b0;
      r_col   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_src <= bus.in_data;
        r_byp <= bus.in_last & BYPASS_EN;
        r_col <= 2'd0;
      end else if (r_state == RUN) begin
        r_col <= r_col + 2'd1;
        case (r_col)
          2'd0:    r_out[127:96] <= w_res_col;
          2'd1:    r_out[95:64]  <= w_res_col;
          2'd2:    r_out[63:32]  <= w_res_col;
          default: r_out[31:0]   <= w_res_col;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mix_col_serial.sv
// Directed bench for mix_col_serial: FIPS-197 column vectors, bypass on both
// parameter settings, backpressure, back-to-back stream and mid-run reset.
module tb_mix_col_serial;

  localparam logic [127:0] D1 = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] E1 = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] D2 = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] E2 = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  // D2 with its columns reordered; MixColumns acts per column so E2 reorders alike.
  localparam logic [127:0] D3 = 128'h2d26314c_01010101_db135345_f20a225c;
  localparam logic [127:0] E3 = 128'h4d7ebdf8_01010101_8e4da1bc_9fdc589d;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [127:0] exp_q[$];

  mix_col_serial_if if1();
  mix_col_serial_if if2();

  mix_col_serial #(.BYPASS_EN(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  mix_col_serial #(.BYPASS_EN(1'b0)) u_dut_nobyp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends one block on if1 with out_ready high and walks it through RUN.
  task automatic run_block(input string tag, input logic [127:0] d, input logic l,
                           input logic [127:0] e);
    @(negedge clk);
    check({tag, "_in_ready"}, if1.in_ready, 1);
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    if1.in_last  = l;
    @(negedge clk);
    if1.in_valid = 1'b0;
    if1.in_data  = {$urandom, $urandom, $urandom, $urandom};
    if1.in_last  = ~l;
    for (int k = 0; k < 4; k++) begin
      check({tag, "_busy"}, if1.busy, 1);
      check({tag, "_col_idx"}, if1.col_idx, k[1:0]);
      check({tag, "_early_valid"}, if1.out_valid, 0);
      @(negedge clk);
    end
    check({tag, "_out_valid"}, if1.out_valid, 1);
    check({tag, "_out_data"}, if1.out_data, e);
    check({tag, "_busy_done"}, if1.busy, 0);
    @(negedge clk);
    check({tag, "_valid_drop"}, if1.out_valid, 0);
  endtask

  initial begin
    logic [127:0] blk[3];
    logic [127:0] exp;
    int sent;
    int last_out;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_last = 1'b0; if2.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", if1.in_ready, 1);
    check("rst_out_valid", if1.out_valid, 0);
    check("rst_out_data", if1.out_data, 0);
    check("rst_busy", if1.busy, 0);
    check("rst_col_idx", if1.col_idx, 0);
    rst_n = 1'b1;

    run_block("single", D1, 1'b0, E1);
    run_block("column", D2, 1'b0, E2);
    run_block("bypass", D1, 1'b1, D1);

    // in_last must be ignored when the bypass is compiled out.
    @(negedge clk);
    if2.in_valid = 1'b1;
    if2.in_data  = D1;
    if2.in_last  = 1'b1;
    @(negedge clk);
    if2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("nobyp_out_valid", if2.out_valid, 1);
    check("nobyp_out_data", if2.out_data, E1);

    // Backpressure: hold DONE for 10 cycles with a new block pending.
    if1.out_ready = 1'b0;
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.in_data  = D2;
    if1.in_last  = 1'b0;
    @(negedge clk);
    if1.in_data = D1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", if1.out_valid, 1);
      check("bp_out_data", if1.out_data, E2);
      check("bp_in_ready", if1.in_ready, 0);
      check("bp_busy", if1.busy, 0);
      @(negedge clk);
    end
    if1.out_ready = 1'b1;
    #1;
    check("bp_release_ready", if1.in_ready, 1);
    @(negedge clk);
    if1.in_valid = 1'b0;
    if1.in_data  = '0;
    check("bp_resume_busy", if1.busy, 1);
    check("bp_resume_valid", if1.out_valid, 0);
    check("bp_resume_col", if1.col_idx, 0);
    repeat (4) @(negedge clk);
    check("bp_second_valid", if1.out_valid, 1);
    check("bp_second_data", if1.out_data, E1);
    @(negedge clk);
    check("bp_idle", if1.out_valid, 0);

    // Back-to-back stream of three blocks.
    blk = '{D1, D2, D3};
    exp_q.push_back(E1);
    exp_q.push_back(E2);
    exp_q.push_back(E3);
    sent = 0;
    last_out = -1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (if1.out_valid) begin
        exp = exp_q.pop_front();
        check("stream_data", if1.out_data, exp);
        if (last_out >= 0) check("stream_gap", cyc - last_out, 5);
        last_out = cyc;
      end
      if (sent < 3) begin
        if1.in_valid = 1'b1;
        if1.in_data  = blk[sent];
        if1.in_last  = 1'b0;
      end else begin
        if1.in_valid = 1'b0;
      end
      #1;
      if (if1.in_valid && if1.in_ready) sent++;
    end
    check("stream_drained", exp_q.size(), 0);
    if1.in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of RUN at col_idx=2.
    @(negedge clk);
    if1.in_valid = 1'b1;
    if1.in_data  = D1;
    if1.in_last  = 1'b0;
    @(negedge clk);
    if1.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_col_idx", if1.col_idx, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", if1.in_ready, 1);
    check("mid_rst_out_valid", if1.out_valid, 0);
    check("mid_rst_out_data", if1.out_data, 0);
    check("mid_rst_busy", if1.busy, 0);
    check("mid_rst_col_idx", if1.col_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block("post_rst", D2, 1'b0, E2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
